ram_bist_ctrl: RTL
==================

// Module: ram_bist_ctrl
// PURPOSE
//  Built-in self-test sequencer for the single-port block RAM (blk_mem_gen_0, 32x8).
//  Drives the RAM port (en/we/addr/wdata) upstream of the RAM and consumes its read data.
//  On a start pulse it writes a deterministic pattern to every address, then reads each one back.
//  It compares the read data against the pattern and reports pass/fail, the error count
//  and the first failing address.
// PARAMETERS
//  ADDR_W   5      RAM address width; depth N = 2**ADDR_W
//  DATA_W   8      RAM data width
//  RD_LAT   1      RAM read latency in cycles (>=1); 1 = blk_mem without output register
//  SEED     8'hA5  pattern offset; pattern(a) = (a + SEED) mod 2**DATA_W
// PORTS
//  sys_clk         in   1         single clock; all logic on rising edge
//  sys_rst         in   1         synchronous, active-high reset
//  start           in   1         one-cycle request to run the test; ignored unless IDLE
//  ram_en          out  1         RAM enable (ena)
//  ram_we          out  1         RAM write enable (wea)
//  ram_addr        out  ADDR_W    RAM address (addra)
//  ram_wdata       out  DATA_W    RAM write data (dina)
//  ram_rdata       in   DATA_W    RAM read data (douta)
//  busy            out  1         high from the cycle after start is accepted until done
//  done            out  1         one-cycle pulse at the end of the test
//  pass            out  1         1 = last run had zero mismatches; held until next start
//  err_cnt         out  ADDR_W+1  mismatch count of current/last run (max N, cannot wrap)
//  first_err_addr  out  ADDR_W    address of the first mismatch; 0 if none
// BEHAVIOUR
//  Reset:
//   - One clock and one reset. Reset is synchronous and active-high: sys_rst sampled on the rising sys_clk edge.
//   - All outputs are registered and reset to 0. The FSM returns to IDLE.
//   - Reset mid-run aborts immediately: en/we drop on the next edge, no further RAM access, no done pulse.
//  FSM states and transitions:
//   - IDLE -> WRITE on start.
//   - WRITE -> READ after N cycles.
//   - READ -> DRAIN after N cycles.
//   - DRAIN -> DONE after RD_LAT cycles.
//   - DONE -> IDLE after 1 cycle.
//  Start acceptance:
//   - Let k = the edge that samples start=1 in IDLE.
//   - At edge k: err_cnt, pass and first_err_addr are cleared; busy=1.
//   - start in any state other than IDLE is ignored (includes the DONE cycle).
//  Output timing after edge k:
//   - WRITE cycles k..k+N-1: en=1, we=1, addr = 0..N-1 ascending, wdata = pattern(addr).
//   - READ cycles k+N..k+2N-1: en=1, we=0, addr = 0..N-1 ascending, wdata=0.
//   - DRAIN and DONE: en=0, we=0, addr=0.
//  Compare pipeline:
//   - A read driven in cycle c has ram_rdata compared in cycle c+RD_LAT.
//   - The expected address and valid flag travel through an RD_LAT-deep shift register; ram_rdata is not re-registered before the compare.
//   - On each valid mismatch, err_cnt increments by 1.
//   - first_err_addr captures the address only when err_cnt==0 before the increment.
//  Completion:
//   - done=1 for exactly one cycle, after edge k+2N+RD_LAT. In that same cycle busy drops to 0.
//   - pass = (final err_cnt==0) is updated with done and held until the next accepted start.
//  Widths:
//   - The pattern add is truncated to DATA_W.
//   - The address counter wraps only at the WRITE->READ and READ->DRAIN transitions. It never exceeds N-1.
// TESTING
//  1. Good RAM model, RD_LAT=1, start at edge k
//     -> 32 writes (addr0=A5, addr31=C4), then 32 reads.
//     -> done pulse after edge k+65; pass=1, err_cnt=0, first_err_addr=0.
//  2. RAM model with data bit0 stuck at 0
//     -> mismatch at every address whose pattern has bit0=1 (16 addresses).
//     -> err_cnt=16, first_err_addr=0 (pattern A5 has bit0=1), pass=0.
//  3. Model corrupting only address 7 on read
//     -> err_cnt=1, first_err_addr=7, pass=0.
//     -> Rerun with a good model: pass=1, err_cnt=0.
//  4. start re-pulsed during WRITE, READ and the done cycle
//     -> all ignored; exactly one done pulse, timing unchanged.
//  5. sys_rst asserted at cycle k+40 (mid-READ)
//     -> next edge: all outputs 0, no done pulse.
//     -> A new start gives a full normal run.
//  6. RD_LAT=2 with a 2-cycle RAM model
//     -> done after edge k+66, pass=1.
//     -> The same model with RD_LAT=1 must fail: err_cnt>0.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// Self-test sequencer for a single-port RAM: writes pattern(a) = a + SEED to every address, then reads each address back and checks it.
// A run takes 2N + RD_LAT + 1 cycles from start to the done pulse. There is no backpressure: start is only accepted while IDLE.
module ram_bist_ctrl #(
   parameter int                ADDR_W = 5,
   parameter int                DATA_W = 8,
   parameter int                RD_LAT = 1,
   parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              start,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic                en_q, en_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0]   first_q, first_d;

   // Expected address and valid flag, delayed to line up with ram_rdata.
   logic                pipe_vld_q  [RD_LAT];
   logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];

   logic                cmp_vld;
   logic [ADDR_W-1:0]   cmp_addr;
   logic [DATA_W-1:0]   cmp_exp;
   logic                mismatch;

   assign cmp_vld  = pipe_vld_q[RD_LAT-1];
   assign cmp_addr = pipe_addr_q[RD_LAT-1];
   assign cmp_exp  = DATA_W'(cmp_addr) + SEED;
   assign mismatch = cmp_vld && (ram_rdata != cmp_exp);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lat_d     = lat_q;
      pass_d    = pass_q;
      err_cnt_d = err_cnt_q;
      first_d   = first_q;

      if (mismatch) begin
         err_cnt_d = err_cnt_q + 1'b1;
         if (err_cnt_q == '0) begin
            first_d = cmp_addr;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_WRITE;
               cnt_d     = '0;
               err_cnt_d = '0;
               pass_d    = 1'b0;
               first_d   = '0;
            end
         end
         S_WRITE: begin
            // The counter wraps to 0 on its own as the last address is reached.
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d = S_DRAIN;
               lat_d   = '0;
            end
         end
         S_DRAIN: begin
            if (lat_q == LAT_W'(RD_LAT - 1)) begin
               state_d = S_DONE;
               pass_d  = (err_cnt_d == '0);
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered, so they are decoded from the next state.
      en_d    = (state_d == S_WRITE) || (state_d == S_READ);
      we_d    = (state_d == S_WRITE);
      wdata_d = we_d ? (DATA_W'(cnt_d) + SEED) : '0;
      busy_d  = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         lat_q     <= '0;
         en_q      <= 1'b0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_cnt_q <= '0;
         first_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lat_q     <= lat_d;
         en_q      <= en_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_cnt_q <= err_cnt_d;
         first_q   <= first_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_vld_q[i]  <= 1'b0;
            pipe_addr_q[i] <= '0;
         end
      end else begin
         pipe_vld_q[0]  <= en_q && !we_q;
         pipe_addr_q[0] <= cnt_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_addr_q[i] <= pipe_addr_q[i-1];
         end
      end
   end

   assign ram_en         = en_q;
   assign ram_we         = we_q;
   assign ram_addr       = cnt_q;
   assign ram_wdata      = wdata_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_q;

endmodule
